// File: rtl/dp_mem_responder_if.sv
// Datapath/cache and cache/RAM handshake bundle for dp_mem_responder.
// slave: the responder. master: the datapath plus memory controller side.
interface dp_mem_responder_if;
  // Datapath requests
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  // Datapath responses
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic [31:0] dmemload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  // Status
  logic        mem_err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramready,
    output ihit, imemload, dhit, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore,
    output mem_err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramready,
    input  ihit, imemload, dhit, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    input  mem_err
  );
endinterface

// File: rtl/dp_mem_responder.sv
// Cache-side responder: arbitrates instruction fetches and data accesses onto
// a single-port word RAM, runs the RAM handshake with a timeout, and returns
// one-cycle ihit/dhit pulses with the loaded word.
module dp_mem_responder #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input logic               CLK,
  input logic               nRST,
  dp_mem_responder_if.slave dcif
);

  // Counter value seen in the last permitted ACCESS cycle.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        write_q, write_d;
  logic        is_data_q, is_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmemload_q, dmemload_d;

  logic        capture;
  logic [31:0] capture_word;
  logic        dreq;

  assign dreq = dcif.dmemREN | dcif.dmemWEN;

  // State and latched request registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      store_q    <= '0;
      write_q    <= 1'b0;
      is_data_q  <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      write_q    <= write_d;
      is_data_q  <= is_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
    end
  end

  // Next-state: arbitration in IDLE, RAM handshake and timeout in ACCESS.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    store_d      = store_q;
    write_d      = write_q;
    is_data_d    = is_data_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    imemload_d   = imemload_q;
    dmemload_d   = dmemload_q;
    capture      = 1'b0;
    capture_word = '0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (dreq) begin
          // Data wins; a simultaneous read+write is serviced as a write.
          addr_d    = dcif.dmemaddr;
          store_d   = dcif.dmemstore;
          write_d   = dcif.dmemWEN;
          is_data_d = 1'b1;
          if (dcif.dmemREN && dcif.dmemWEN) begin
            err_d = 1'b1;
          end
          if (dcif.dmemaddr[1:0] != 2'b00) begin
            err_d        = 1'b1;
            state_d      = StResp;
            capture      = ~dcif.dmemWEN;
            capture_word = '0;
          end else begin
            state_d = StAccess;
          end
        end else if (dcif.imemREN) begin
          addr_d    = dcif.imemaddr;
          store_d   = '0;
          write_d   = 1'b0;
          is_data_d = 1'b0;
          if (dcif.imemaddr[1:0] != 2'b00) begin
            err_d        = 1'b1;
            state_d      = StResp;
            capture      = 1'b1;
            capture_word = '0;
          end else begin
            state_d = StAccess;
          end
        end
      end

      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        if (dcif.ramready) begin
          state_d      = StResp;
          capture      = ~write_q;
          capture_word = dcif.ramload;
        end else if (cnt_q == TimeoutLast) begin
          state_d      = StResp;
          err_d        = 1'b1;
          capture      = ~write_q;
          capture_word = ERR_WORD;
        end
      end

      StResp: begin
        // Always back through IDLE so the datapath can drop the request.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (capture) begin
      if (is_data_d) begin
        dmemload_d = capture_word;
      end else begin
        imemload_d = capture_word;
      end
    end
  end

  // Outputs decoded from registered state only, so reset clears them at once.
  always_comb begin
    dcif.ramREN   = (state_q == StAccess) && !write_q;
    dcif.ramWEN   = (state_q == StAccess) && write_q;
    dcif.ramaddr  = (state_q == StAccess) ? addr_q : '0;
    dcif.ramstore = (state_q == StAccess) ? store_q : '0;
    dcif.ihit     = (state_q == StResp) && !is_data_q;
    dcif.dhit     = (state_q == StResp) && is_data_q;
    dcif.imemload = imemload_q;
    dcif.dmemload = dmemload_q;
    dcif.mem_err  = err_q;
  end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Randomised scoreboard bench for dp_mem_responder with a behavioural RAM.
module tb_dp_mem_responder;

  localparam int TMO = 4;
  localparam logic [31:0] ERR = 32'hBAD1BAD1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   cyc = 0;

  dp_mem_responder_if bus ();

  dp_mem_responder #(
    .TIMEOUT  (TMO),
    .ERR_WORD (ERR)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .dcif (bus.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_data;
    logic [31:0] iload;
    logic [31:0] dload;
    bit          err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] store;
    int          lat;
  } ram_t;

  exp_t        exp_q[$];
  ram_t        ram_q[$];
  logic [31:0] mem[0:255];
  logic [31:0] ref_mem[0:255];
  logic [31:0] last_iload = '0;
  logic [31:0] last_dload = '0;
  bit          err_sticky = 1'b0;
  int          checks = 0;
  int          fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: one request's outcome from address alignment and RAM latency.
  task automatic model_req(input bit is_data, input bit wr, input bit both,
                           input logic [31:0] addr, input logic [31:0] store,
                           input int lat, input int start, output int hit);
    exp_t e;
    ram_t r;
    int   eff;
    if (both) err_sticky = 1'b1;
    if (addr[1:0] != 2'b00) begin
      err_sticky = 1'b1;
      eff = 0;
      if (!wr) begin
        if (is_data) last_dload = '0;
        else last_iload = '0;
      end
    end else begin
      r.addr = addr; r.wr = wr; r.store = store; r.lat = lat;
      ram_q.push_back(r);
      if (lat > TMO) begin
        eff = TMO;
        err_sticky = 1'b1;
        if (!wr) begin
          if (is_data) last_dload = ERR;
          else last_iload = ERR;
        end
      end else begin
        eff = lat;
        if (wr) ref_mem[addr[9:2]] = store;
        else if (is_data) last_dload = ref_mem[addr[9:2]];
        else last_iload = ref_mem[addr[9:2]];
      end
    end
    hit = start + eff + 1;
    e.is_data = is_data; e.iload = last_iload; e.dload = last_dload;
    e.err = err_sticky; e.cyc = hit;
    exp_q.push_back(e);
  endtask

  // Behavioural RAM: ready after the latency chosen for the current access.
  int   acc_cnt = 0;
  ram_t cur;
  always @(negedge CLK) begin
    if (!nRST) begin
      acc_cnt = 0;
      bus.ramready = 1'b0;
      bus.ramload = '0;
    end else if (bus.ramREN || bus.ramWEN) begin
      if (acc_cnt == 0) begin
        if (ram_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_strobe: got ramaddr %h, expected no access", bus.ramaddr);
          cur.addr = bus.ramaddr; cur.wr = bus.ramWEN; cur.store = bus.ramstore; cur.lat = 1;
        end else begin
          cur = ram_q.pop_front();
        end
      end
      acc_cnt++;
      chk("ram_strobe_excl", 32'(bus.ramREN && bus.ramWEN), 32'd0);
      chk("ramaddr", bus.ramaddr, cur.addr);
      chk("ramWEN", 32'(bus.ramWEN), 32'(cur.wr));
      if (cur.wr) chk("ramstore", bus.ramstore, cur.store);
      if (acc_cnt == cur.lat) begin
        bus.ramready = 1'b1;
        bus.ramload = mem[bus.ramaddr[9:2]];
        if (bus.ramWEN) mem[bus.ramaddr[9:2]] = bus.ramstore;
      end else begin
        bus.ramready = 1'b0;
        bus.ramload = $urandom;
      end
    end else begin
      acc_cnt = 0;
      bus.ramready = 1'b0;
      bus.ramload = $urandom;
    end
  end

  // Monitor: every hit is matched against the oldest expected response.
  always @(negedge CLK) begin
    if (nRST && (bus.ihit || bus.dhit)) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL stray_hit: got ihit=%0b dhit=%0b, expected none", bus.ihit, bus.dhit);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit_source", {30'd0, bus.dhit, bus.ihit}, e.is_data ? 32'd2 : 32'd1);
        chk("imemload", bus.imemload, e.iload);
        chk("dmemload", bus.dmemload, e.dload);
        chk("mem_err", 32'(bus.mem_err), 32'(e.err));
        chk("hit_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue from an IDLE cycle, hold each request until its hit, then settle.
  task automatic issue(input bit d_ren, input bit d_wen, input bit i_ren,
                       input logic [31:0] daddr, input logic [31:0] dstore,
                       input logic [31:0] iaddr, input int dlat, input int ilat);
    int pend;
    int t;
    int h;
    pend = 0;
    t = cyc;
    if (d_ren || d_wen) begin
      model_req(1'b1, d_wen, d_ren && d_wen, daddr, dstore, dlat, t, h);
      t = h + 1;
      pend++;
    end
    if (i_ren) begin
      model_req(1'b0, 1'b0, 1'b0, iaddr, '0, ilat, t, h);
      pend++;
    end
    bus.dmemREN = d_ren; bus.dmemWEN = d_wen;
    bus.dmemaddr = daddr; bus.dmemstore = dstore;
    bus.imemREN = i_ren; bus.imemaddr = iaddr;
    for (int k = 0; k < 64 && pend > 0; k++) begin
      @(negedge CLK);
      if (bus.dhit) begin bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; pend--; end
      if (bus.ihit) begin bus.imemREN = 1'b0; pend--; end
    end
    if (pend > 0) begin
      checks++; fails++;
      $display("FAIL hit_timeout: got %0d hits outstanding, expected 0", pend);
      bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.imemREN = 1'b0;
    end
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1);
  end

  initial begin
    bus.imemREN = 1'b0; bus.imemaddr = '0;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    bus.dmemaddr = '0; bus.dmemstore = '0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[8'h10] = 32'h8C220004;
    ref_mem[8'h10] = 32'h8C220004;

    #3;
    chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_dhit", 32'(bus.dhit), 32'd0);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);
    chk("rst_dmemload", bus.dmemload, 32'd0);
    chk("rst_mem_err", 32'(bus.mem_err), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    issue(1'b0, 1'b0, 1'b1, '0, '0, 32'h40, 0, 1);                   // fetch
    issue(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, '0, 3, 0);        // write, 3 cycles
    issue(1'b1, 1'b0, 1'b1, 32'h200, '0, 32'h0, 1, 1);               // priority
    issue(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 2, 0);                  // read back
    issue(1'b1, 1'b0, 1'b0, 32'h300, '0, '0, 9, 0);                  // timeout
    issue(1'b1, 1'b0, 1'b0, 32'h102, '0, '0, 1, 0);                  // misaligned

    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [31:0] da;
      logic [31:0] ia;
      da = {22'd0, 8'($urandom), 2'b00};
      ia = {22'd0, 8'($urandom), 2'b00};
      if ($urandom_range(0, 9) == 0) da[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: issue(1'b1, 1'b0, 1'b0, da, $urandom, ia, $urandom_range(1, 6), 1);
        3, 4:    issue(1'b0, 1'b1, 1'b0, da, $urandom, ia, $urandom_range(1, 6), 1);
        5:       issue(1'b1, 1'b1, 1'b0, da, $urandom, ia, $urandom_range(1, 6), 1);
        6, 7, 8: issue(1'b0, 1'b0, 1'b1, da, $urandom, ia, 1, $urandom_range(1, 6));
        default: issue(1'b1, $urandom_range(0, 1) == 1, 1'b1, da, $urandom, ia,
                       $urandom_range(1, 6), $urandom_range(1, 6));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // Reset during the second ACCESS cycle of a slow fetch.
    ram_q.delete();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
    begin
      ram_t r;
      r.addr = 32'h40; r.wr = 1'b0; r.store = '0; r.lat = 20;
      ram_q.push_back(r);
    end
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_ramREN", 32'(bus.ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("mid_rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("mid_rst_ihit", 32'(bus.ihit), 32'd0);
    chk("mid_rst_dhit", 32'(bus.dhit), 32'd0);
    chk("mid_rst_mem_err", 32'(bus.mem_err), 32'd0);
    chk("mid_rst_imemload", bus.imemload, 32'd0);
    bus.imemREN = 1'b0;
    ram_q.delete();
    exp_q.delete();
    err_sticky = 1'b0; last_iload = '0; last_dload = '0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (5) @(negedge CLK);
    issue(1'b0, 1'b0, 1'b1, '0, '0, 32'h40, 0, 2);
    issue(1'b1, 1'b0, 1'b0, 32'h80, '0, '0, 1, 0);
    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL missing_hits: got %0d unmatched, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
- Cache-side responder for datapath_cache_if. Services the datapath's instruction fetches (imemREN) and data loads/stores (dmemREN/dmemWEN) against a single-port word RAM.
- Arbitrates between the two request sources, runs the RAM handshake, and returns ihit/dhit pulses with load data.
- Sits between the datapath and the memory controller in the single-cycle CPU.

Parameters:
- TIMEOUT, 255, max cycles in ACCESS waiting for ramready before a forced error completion (1..255)
- ERR_WORD, 32'hBAD1BAD1, load value returned on timeout

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  instruction read request, level
- imemaddr  input  32  instruction byte address
- dmemREN  input  1  data read request, level
- dmemWEN  input  1  data write request, level
- dmemaddr  input  32  data byte address
- dmemstore  input  32  data write value
- ihit  output  1  instruction request complete, one-cycle pulse
- imemload  output  32  fetched instruction, valid while ihit=1
- dhit  output  1  data request complete, one-cycle pulse
- dmemload  output  32  loaded word, valid while dhit=1 after a read
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM byte address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid when ramready=1
- ramready  input  1  RAM access complete this cycle
- mem_err  output  1  sticky error flag

Behaviour:
- Reset: all outputs are 0. State goes to IDLE, the timeout counter to 0, and the latched request is cleared.
- Reset asserted mid-access drops ramREN/ramWEN immediately (asynchronously). No hit is ever produced for the aborted request.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If dmemREN or dmemWEN is high: latch a data request (address, store data, write = dmemWEN) and go to ACCESS. Data has priority over instruction.
  - Else if imemREN is high: latch an instruction read and go to ACCESS.
  - Else stay in IDLE.
- dmemREN and dmemWEN both high: treat as a write and set mem_err.
- Misaligned latched address (addr[1:0] != 0): skip ACCESS and go directly to RESP. Set mem_err. Load value is 0. The RAM is never strobed.
- ACCESS:
  - Drive ramaddr and ramstore from the latched request. Drive ramREN = ~write and ramWEN = write.
  - ramREN and ramWEN are never both high.
  - Inputs are not resampled in ACCESS, so address or data changes from the datapath have no effect.
- ramready=1 in ACCESS: capture ramload (reads only) and go to RESP. RAM strobes deassert in RESP.
- Timeout: the counter increments each ACCESS cycle. When it reaches TIMEOUT with no ramready, go to RESP, set mem_err, and use ERR_WORD as the load value.
- RESP lasts exactly 1 cycle:
  - Pulse ihit or dhit, matching the latched source.
  - imemload or dmemload shows the captured word.
  - A write completes with dhit=1; dmemload holds its previous value.
  - RESP always returns to IDLE, which gives the datapath one cycle to retire the request before re-arbitration.
- Latency from request seen in IDLE (cycle 0):
  - ACCESS in cycle 1.
  - With ramready in cycle 1, the hit is in cycle 2. Minimum request-to-hit is 2 cycles.
  - With N ACCESS cycles, the hit is in cycle N+1.
- The hit signal that was not pulsed stays 0. imemload and dmemload hold their last values between hits.
- Starvation: a data request pending in IDLE always wins. The instruction fetch is served on the next IDLE in which no data request is pending.
- mem_err clears only on reset.

Test Plan:
- Fetch: imemREN=1, imemaddr=0x40, ramready=1 on first ACCESS cycle, ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 in cycle 1; ihit=1 and imemload=0x8C220004 in cycle 2 only; dhit=0.
- Write with latency: dmemWEN=1, dmemaddr=0x100, dmemstore=0xDEADBEEF, ramready after 3 ACCESS cycles -> ramWEN=1 and ramstore=0xDEADBEEF for 3 cycles; ramREN=0 throughout; dhit pulses in cycle 4; mem_err=0.
- Priority: imemREN=1 and dmemREN=1 together (imemaddr=0x0, dmemaddr=0x200) -> first access has ramaddr=0x200 and completes with dhit. Then RESP, then IDLE, then access with ramaddr=0x0 and ihit.
- Timeout: TIMEOUT=4, dmemREN=1, ramready held 0 -> exactly 4 ACCESS cycles; dhit=1 with dmemload=0xBAD1BAD1; mem_err=1 and stays set.
- Misaligned: dmemREN=1, dmemaddr=0x102 -> no ramREN/ramWEN at any time; dhit in cycle 1 with dmemload=0; mem_err=1.
- Reset mid-op: nRST low during the 2nd ACCESS cycle -> ramREN/ramWEN, ihit, dhit and mem_err are 0 immediately; after release, state is IDLE and no stale hit occurs.
